// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's load/store port. Holds a byte-addressable
// scratch RAM of 2**ADDR_W bytes (organised as 32-bit words) and answers each
// accepted request after WAIT_STATES extra cycles through a valid/ready
// handshake. Funct3 selects byte/half/word access, with sign or zero extension
// on loads (000 b, 001 h, 010 w, 100 bu, 101 hu; 011/110/111 act as word).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   core presents a request
//   req_ready  out  responder can accept (high only in IDLE)
//   WR         in   store request (wins when RD is also high)
//   RD         in   load request
//   Address    in   byte address, ADDR_W bits
//   Funct3     in   access size / sign
//   WRData     in   store data, right-aligned
//   RDData     out  load result, registered, held until the next response
//   rsp_valid  out  one-cycle pulse marking request completion
//   err        out  misalignment flag, qualified by rsp_valid
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses complete with err=1, no RAM
//               write and RDData=0
//   undefined : err tied low; half ignores Address[0], word ignores
//               Address[1:0]
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] Address,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] WRData,
    output logic [DATA_W-1:0] RDData,
    output logic              rsp_valid,
    output logic              err
);

    // state  | meaning
    // S_IDLE | ready for a request, req_ready high
    // S_WAIT | request latched, counting down wait states
    // S_RESP | request committed, rsp_valid pulsed for this cycle

    localparam int         WORDS    = (2 ** ADDR_W) / 4;
    localparam int         IDX_W    = ADDR_W - 2;
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [WORDS];

    logic              accept;
    logic              commit;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [2:0]        c_f3;
    logic [DATA_W-1:0] c_wdata;
    logic              is_byte;
    logic              is_half;
    logic              is_unsigned;
    logic              bad;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] ram_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] st_word;
    logic [3:0]        st_be;

    assign accept = (state == S_IDLE) && req_ready && req_valid && (WR || RD);

    // With no wait states the commit edge is the accept edge itself, so the
    // datapath has to look at the live inputs while in IDLE; otherwise it works
    // from the copy latched at accept.
    assign c_wr    = (state == S_IDLE) ? WR      : op_wr_q;
    assign c_addr  = (state == S_IDLE) ? Address : addr_q;
    assign c_f3    = (state == S_IDLE) ? Funct3  : f3_q;
    assign c_wdata = (state == S_IDLE) ? WRData  : wdata_q;

    assign commit = NO_WAIT ? accept : ((state == S_WAIT) && (cnt == 4'd0));

    assign lane = c_addr[1:0];
    assign idx  = c_addr[ADDR_W-1:2];

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (c_f3)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            default:        ;
        endcase
    end

    assign is_unsigned = c_f3[2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign bad = (is_half && c_addr[0]) ||
                 (!is_byte && !is_half && (c_addr[1:0] != 2'b00));
`else
    assign bad = 1'b0;
`endif

    // Load path: select lane from the addressed word, then extend.
    assign ram_word = mem[idx];
    assign ld_byte  = ram_word[{lane, 3'b000} +: 8];
    assign ld_half  = lane[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        if (is_byte) begin
            ld_val = {{(DATA_W-8){ld_byte[7] & ~is_unsigned}}, ld_byte};
        end else if (is_half) begin
            ld_val = {{(DATA_W-16){ld_half[15] & ~is_unsigned}}, ld_half};
        end else begin
            ld_val = ram_word;
        end
    end

    // Store path: replicate the right-aligned data into every lane and let
    // the byte enables pick which lanes actually change.
    always_comb begin
        st_word = c_wdata;
        st_be   = 4'b1111;
        if (is_byte) begin
            st_word = {4{c_wdata[7:0]}};
            st_be   = 4'b0001 << lane;
        end else if (is_half) begin
            st_word = {2{c_wdata[15:0]}};
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && c_wr && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            RDData    <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            f3_q      <= 3'b000;
            wdata_q   <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        op_wr_q   <= WR;
                        addr_q    <= Address;
                        f3_q      <= Funct3;
                        wdata_q   <= WRData;
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase

            // Stores (including WR+RD together) and rejected accesses
            // return zero.
            if (commit) begin
                RDData <= (c_wr || bad) ? '0 : ld_val;
`ifdef DMEM_MISALIGN_CHECK_EN
                err_q  <= bad;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders run side by side: index 0 with WAIT_STATES=1, index 1 with
// WAIT_STATES=0. A byte-array model tracks RAM contents and request timing in
// terms of edge numbers since reset release; a compare process checks every
// output of both instances on every falling edge. Directed sequences pin the
// model with hand-computed literals, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI   = 2;
    localparam int WS_A = 1;
    localparam int WS_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        req_valid [NI];
    logic        wr        [NI];
    logic        rd        [NI];
    logic [8:0]  addr      [NI];
    logic [2:0]  f3        [NI];
    logic [31:0] wdata     [NI];
    logic        req_ready [NI];
    logic        rsp_valid [NI];
    logic        err       [NI];
    logic [31:0] rdata     [NI];

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .WR(wr[0]), .RD(rd[0]), .Address(addr[0]), .Funct3(f3[0]), .WRData(wdata[0]),
        .RDData(rdata[0]), .rsp_valid(rsp_valid[0]), .err(err[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .WR(wr[1]), .RD(rd[1]), .Address(addr[1]), .Funct3(f3[1]), .WRData(wdata[1]),
        .RDData(rdata[1]), .rsp_valid(rsp_valid[1]), .err(err[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state. n_e counts rising edges since reset release; the outputs
    // seen after edge n are compared against it.
    int          n_e        [NI];
    int          busy_until [NI];
    bit          pend       [NI];
    int          commit_n   [NI];
    int          resp_n     [NI];
    bit          acc_evt    [NI];
    bit          p_wr       [NI];
    logic [8:0]  p_addr     [NI];
    logic [2:0]  p_f3       [NI];
    logic [31:0] p_wdata    [NI];
    logic [7:0]  mem_m      [NI][512];
    logic [31:0] exp_rd     [NI];
    logic        exp_err    [NI];

    function automatic int ws_of(int i);
        return (i == 0) ? WS_A : WS_B;
    endfunction

    task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, i, got, exp, $time);
        end
    endtask

    task automatic model_apply(int i);
        int size;
        int a;
        int base;
        bit mis;
        logic [31:0] v;
        a = int'(p_addr[i]);
        if (p_f3[i] == 3'b000 || p_f3[i] == 3'b100)      size = 1;
        else if (p_f3[i] == 3'b001 || p_f3[i] == 3'b101) size = 2;
        else                                             size = 4;
        base = a - (a % size);
        mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (a % size) != 0;
`endif
        exp_err[i] = mis;
        if (mis) begin
            exp_rd[i] = 32'd0;
        end else if (p_wr[i]) begin
            for (int k = 0; k < size; k++) mem_m[i][base + k] = p_wdata[i][8*k +: 8];
            exp_rd[i] = 32'd0;
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(mem_m[i][base + k]) << (8 * k));
            if (size < 4 && !p_f3[i][2] && v[8*size-1]) v = v - (32'd1 << (8 * size));
            exp_rd[i] = v;
        end
    endtask

    task automatic model_step(int i);
        int np;
        if (!rst[i]) begin
            n_e[i] = 0; busy_until[i] = 0; pend[i] = 1'b0; resp_n[i] = -1;
            acc_evt[i] = 1'b0; exp_rd[i] = 32'd0; exp_err[i] = 1'b0;
            return;
        end
        np = n_e[i];
        n_e[i] = np + 1;
        acc_evt[i] = 1'b0;
        if (np >= 1 && np >= busy_until[i] && req_valid[i] && (wr[i] || rd[i])) begin
            acc_evt[i]    = 1'b1;
            pend[i]       = 1'b1;
            commit_n[i]   = n_e[i] + ws_of(i);
            busy_until[i] = n_e[i] + ws_of(i) + 1;
            p_wr[i]       = wr[i];
            p_addr[i]     = addr[i];
            p_f3[i]       = f3[i];
            p_wdata[i]    = wdata[i];
        end
        if (pend[i] && n_e[i] == commit_n[i]) begin
            model_apply(i);
            pend[i]   = 1'b0;
            resp_n[i] = n_e[i];
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst[i]) begin
                chk("rst_req_ready", i, 32'(req_ready[i]), 32'd0);
                chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
                chk("rst_rddata",    i, rdata[i],          32'd0);
                chk("rst_err",       i, 32'(err[i]),       32'd0);
            end else begin
                chk("req_ready", i, 32'(req_ready[i]),
                    32'(n_e[i] >= 1 && n_e[i] >= busy_until[i]));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(resp_n[i] == n_e[i]));
                chk("rddata", i, rdata[i], exp_rd[i]);
                if (resp_n[i] == n_e[i]) chk("err", i, 32'(err[i]), 32'(exp_err[i]));
            end
        end
    end

    // Issue one request and wait for its response. lat counts falling edges
    // from the accept edge to the one where rsp_valid is seen.
    task automatic do_req(int i, bit w, bit r, logic [8:0] a, logic [2:0] f, logic [31:0] d,
                          output int lat, output logic [31:0] got, output logic got_err);
        bit ok;
        lat = -1; got = 'x; got_err = 1'bx;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; wr[i] = w; rd[i] = r; addr[i] = a; f3[i] = f; wdata[i] = d;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk); #1;
            if (acc_evt[i]) ok = 1'b1;
        end
        // Scramble the request fields; the responder must ignore them now.
        req_valid[i] = 1'b0; wr[i] = 1'($urandom); rd[i] = 1'($urandom);
        addr[i] = 9'($urandom); f3[i] = 3'($urandom); wdata[i] = $urandom;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout[%0d]: no accept within 50 cycles, addr %h", i, a);
            return;
        end
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (rsp_valid[i] === 1'b1) begin
                lat = k; got = rdata[i]; got_err = err[i];
                break;
            end
        end
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout[%0d]: no rsp_valid within 50 cycles, addr %h", i, a);
        end
    endtask

    task automatic release_and_init(int i);
        int lat; logic [31:0] g; logic e;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_rst", i, 32'(req_ready[i]), 32'd0);
        rst[i] = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_cycle", i, 32'(req_ready[i]), 32'd1);
        for (int w = 0; w < 128; w++) do_req(i, 1'b1, 1'b0, 9'(w * 4), 3'b010, 32'd0, lat, g, e);
    endtask

    task automatic rand_phase(int i, int count);
        int kind; int lat; logic [31:0] g; logic e; logic [8:0] a;
        for (int j = 0; j < count; j++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 63));
            if (kind == 0) begin
                @(posedge clk); #1;
                req_valid[i] = 1'b1; wr[i] = 1'b0; rd[i] = 1'b0; addr[i] = a;
                @(posedge clk); #1;
                req_valid[i] = 1'b0;
            end else begin
                do_req(i, kind <= 4, (kind == 1) || (kind >= 5), a, 3'($urandom), $urandom,
                       lat, g, e);
                chk("rand_latency", i, 32'(lat), 32'(ws_of(i) + 1));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic run_a();
        int lat; logic [31:0] g; logic e; int seen;
        bit ok;
        release_and_init(0);

        do_req(0, 1, 0, 9'h010, 3'b010, 32'hDEADBEEF, lat, g, e);
        chk("sw_latency", 0, 32'(lat), 32'd2);
        chk("sw_err", 0, 32'(e), 32'd0);
        do_req(0, 0, 1, 9'h010, 3'b010, 32'd0, lat, g, e); chk("lw_010", 0, g, 32'hDEADBEEF);
        do_req(0, 0, 1, 9'h013, 3'b000, 32'd0, lat, g, e); chk("lb_013", 0, g, 32'hFFFFFFDE);
        do_req(0, 0, 1, 9'h013, 3'b100, 32'd0, lat, g, e); chk("lbu_013", 0, g, 32'h000000DE);
        do_req(0, 0, 1, 9'h010, 3'b001, 32'd0, lat, g, e); chk("lh_010", 0, g, 32'hFFFFBEEF);
        do_req(0, 0, 1, 9'h012, 3'b101, 32'd0, lat, g, e); chk("lhu_012", 0, g, 32'h0000DEAD);

        do_req(0, 1, 0, 9'h011, 3'b000, 32'hAABBCC55, lat, g, e);
        do_req(0, 0, 1, 9'h010, 3'b010, 32'd0, lat, g, e); chk("sb_then_lw", 0, g, 32'hDEAD55EF);
        do_req(0, 1, 0, 9'h012, 3'b001, 32'h99991234, lat, g, e);
        do_req(0, 0, 1, 9'h010, 3'b010, 32'd0, lat, g, e); chk("sh_then_lw", 0, g, 32'h123455EF);

`ifdef DMEM_MISALIGN_CHECK_EN
        do_req(0, 0, 1, 9'h011, 3'b010, 32'd0, lat, g, e);
        chk("mis_lw_err", 0, 32'(e), 32'd1); chk("mis_lw_data", 0, g, 32'd0);
        do_req(0, 1, 0, 9'h013, 3'b001, 32'h0000FFFF, lat, g, e);
        chk("mis_sh_err", 0, 32'(e), 32'd1);
        do_req(0, 0, 1, 9'h010, 3'b010, 32'd0, lat, g, e); chk("mis_sh_nowrite", 0, g, 32'h123455EF);
`else
        do_req(0, 0, 1, 9'h011, 3'b010, 32'd0, lat, g, e);
        chk("lw_011_trunc", 0, g, 32'h123455EF); chk("lw_011_err", 0, 32'(e), 32'd0);
`endif

        do_req(0, 1, 1, 9'h030, 3'b010, 32'h01020304, lat, g, e); chk("wr_rd_zero", 0, g, 32'd0);
        do_req(0, 0, 1, 9'h030, 3'b010, 32'd0, lat, g, e); chk("wr_rd_stored", 0, g, 32'h01020304);
        do_req(0, 0, 1, 9'h034, 3'b110, 32'd0, lat, g, e); chk("f3_110_word", 0, g, 32'd0);

        // Abort a store while it is still waiting for its commit edge.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0;
        addr[0] = 9'h020; f3[0] = 3'b010; wdata[0] = 32'hAAAAAAAA;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge clk); #1;
            if (acc_evt[0]) ok = 1'b1;
        end
        rst[0] = 1'b0; req_valid[0] = 1'b0;
        chk("abort_accepted", 0, 32'(ok), 32'd1);
        seen = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid[0] === 1'b1) seen++; end
        @(posedge clk); #1;
        rst[0] = 1'b1;
        repeat (4) begin @(negedge clk); if (rsp_valid[0] === 1'b1) seen++; end
        chk("abort_no_rsp", 0, 32'(seen), 32'd0);
        do_req(0, 0, 1, 9'h020, 3'b010, 32'd0, lat, g, e); chk("abort_no_write", 0, g, 32'd0);

        rand_phase(0, 200);
    endtask

    task automatic run_b();
        int lat; logic [31:0] g; logic e; int seen; int first; int second;
        release_and_init(1);

        do_req(1, 1, 0, 9'h1FC, 3'b010, 32'hCAFEF00D, lat, g, e);
        chk("sw_latency", 1, 32'(lat), 32'd1);
        do_req(1, 0, 1, 9'h1FC, 3'b010, 32'd0, lat, g, e); chk("lw_1fc", 1, g, 32'hCAFEF00D);
        do_req(1, 0, 1, 9'h1FF, 3'b100, 32'd0, lat, g, e); chk("lbu_1ff", 1, g, 32'h000000CA);
        do_req(1, 0, 1, 9'h1FE, 3'b001, 32'd0, lat, g, e); chk("lh_1fe", 1, g, 32'hFFFFCAFE);
        do_req(1, 0, 1, 9'h000, 3'b010, 32'd0, lat, g, e); chk("lw_000", 1, g, 32'd0);

        // Hold a load valid: accepts must land two cycles apart.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; wr[1] = 1'b0; rd[1] = 1'b1; addr[1] = 9'h1FC; f3[1] = 3'b010;
        first = -1; second = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid[1] === 1'b1) begin
                chk("resp_ready_low", 1, 32'(req_ready[1]), 32'd0);
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("b2b_spacing", 1, 32'(second - first), 32'd2);
        repeat (3) @(posedge clk);

        // Valid without WR or RD must be ignored.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; wr[1] = 1'b0; rd[1] = 1'b0; addr[1] = 9'h010;
        seen = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid[1] === 1'b1) seen++; end
        chk("noop_no_rsp", 1, 32'(seen), 32'd0);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;

        rand_phase(1, 200);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; req_valid[i] = 1'b0; wr[i] = 1'b0; rd[i] = 1'b0;
            addr[i] = 9'd0; f3[i] = 3'd0; wdata[i] = 32'd0;
            n_e[i] = 0; busy_until[i] = 0; pend[i] = 1'b0; commit_n[i] = 0;
            resp_n[i] = -1; acc_evt[i] = 1'b0; exp_rd[i] = 32'd0; exp_err[i] = 1'b0;
            for (int b = 0; b < 512; b++) mem_m[i][b] = 8'd0;
        end
        fork
            run_a();
            run_b();
        join
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the load/store port the RISC-V core drives: WR, RD, Address, WRData out; RDData back. Holds a byte-addressable scratch RAM and answers with a configurable wait-state latency through a valid/ready handshake. Decodes Funct3 for byte, half and word accesses, with sign or zero extension on loads. Sits between the core's memory port and the testbench/SoC, replacing the ideal single-cycle memory.

Parameters:
DATA_W, 32, data width; fixed at 32 for the Funct3 decode.
ADDR_W, 9, byte-address width; RAM holds 2**ADDR_W bytes as (2**ADDR_W)/4 words.
WAIT_STATES, 1, extra cycles between request accept and response (0..15).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
req_valid  in  1  core presents a request this cycle.
req_ready  out  1  responder can accept; high only in IDLE.
WR  in  1  store request.
RD  in  1  load request.
Address  in  ADDR_W  byte address.
Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
WRData  in  DATA_W  store data, right-aligned.
RDData  out  DATA_W  load result, registered, held until next response.
rsp_valid  out  1  one-cycle pulse: request complete.
err  out  1  misalignment flag, qualified by rsp_valid.

Behaviour:
- Reset (rst low): FSM=IDLE, req_ready=0, rsp_valid=0, RDData=0, err=0, wait counter=0. RAM contents are not reset. req_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && (WR||RD) at a clock edge: latch Address, Funct3, WRData and op.
  - Next state is WAIT with counter=WAIT_STATES-1, or RESP if WAIT_STATES=0.
  - req_valid with WR=RD=0 is ignored.
- WAIT: req_ready=0. Counter decrements each cycle. At 0, go to RESP.
- Commit edge (entering RESP):
  - A store writes the RAM.
  - A load samples the RAM into RDData.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- Latency: rsp_valid is high WAIT_STATES+1 cycles after the accept edge. Max throughput is one request per WAIT_STATES+2 cycles.
- WR and RD both high: treated as a store. RDData is set to 0.
- Loads:
  - Word index = Address[ADDR_W-1:2]. Lane = Address[1:0].
  - lb/lbu: selected byte, sign-extended (lb) or zero-extended (lbu).
  - lh/lhu: half-word at lane {Address[1],0}, sign- or zero-extended.
  - lw: whole word.
- Stores:
  - sb writes only lane Address[1:0] with WRData[7:0].
  - sh writes lanes {Address[1],0} and {Address[1],1} with WRData[15:0].
  - sw writes all four lanes.
  - Untouched lanes keep their value.
- Unsupported Funct3 (011, 110, 111): treated as word access.
- Address wraps within ADDR_W bits; there are no out-of-range accesses.
- A load issued immediately after a store to the same word returns the newly written data, since the store committed before the response.
- Reset mid-transaction aborts it. A store whose commit edge has not occurred is not performed. No rsp_valid is issued for the aborted request.
- Inputs are sampled only at the accept edge. Changes during WAIT/RESP are ignored.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined:
  - Half accesses with Address[0]=1, and word accesses with Address[1:0]!=0, complete with normal latency.
  - They set err=1 with rsp_valid, perform no RAM write, and set RDData=0.
- Undefined:
  - err is tied to 0.
  - Low address bits are truncated as described in Behaviour (half ignores Address[0], word ignores Address[1:0]).

Test Plan:
- Reset release, WAIT_STATES=1: req_ready=1 the first cycle after rst goes high. sw 0xDEADBEEF at 0x010 gives rsp_valid exactly 2 cycles after accept. lw 0x010 then returns RDData=0xDEADBEEF.
- Loads of word 0xDEADBEEF at 0x010:
  - lb 0x013 gives 0xFFFFFFDE; lbu 0x013 gives 0x000000DE.
  - lh 0x010 gives 0xFFFFBEEF; lhu 0x012 gives 0x0000DEAD.
- Partial stores:
  - sb 0x55 at 0x011, then lw 0x010, gives 0xDEAD55EF.
  - sh 0x1234 at 0x012, then lw 0x010, gives 0x123455EF.
- Back-to-back and edge cases, WAIT_STATES=0:
  - Request held valid across RESP: two accepts 2 cycles apart; req_ready=0 in RESP.
  - WR=RD=0 with req_valid: no response.
  - Address 0x1FC wraps correctly at ADDR_W=9.
- Reset mid-operation: rst low during WAIT of sw 0xAAAAAAAA to 0x020 (prior value 0). No rsp_valid. A subsequent lw 0x020 returns 0x00000000.
- With DMEM_MISALIGN_CHECK_EN: lw 0x011 gives err=1, RDData=0. sh at 0x013 gives err=1 and memory unchanged. Without the macro, lw 0x011 returns the word at 0x010 and err=0.
